// File: rtl/im_pkg.sv
// ---------------------------------------------------------------------------
// im_pkg
// Shared definitions for the image data packer: frame state encoding, the
// header sync byte and the beats-per-word calculation.
// No ports (package).
// ---------------------------------------------------------------------------
package im_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_PACK  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [7:0] HDR_SYNC = 8'hA5;
    localparam int         WORD_W   = 32;

    // Number of whole sample beats that fit in one host word.
    function automatic int calc_beats_per_word(input int beat_w);
        return WORD_W / beat_w;
    endfunction

endpackage

// File: rtl/im_beat_shifter.sv
// ---------------------------------------------------------------------------
// im_beat_shifter
// Collects sample beats into a word, beat i landing at bits
// [i*BEAT_W +: BEAT_W]. The merged word (stored beats plus the beat being
// shifted in this cycle) is presented combinationally so the owner can
// capture a word on the same cycle its closing beat arrives.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   shift_i     store beat_i at the current index this cycle
//   close_i     the beat shifted this cycle finishes the word
//   drain_i     discard stored beats (owner has captured word_o)
//   beat_i      sample beat
//   word_o      merged word, unused MSBs zero
//   full_o      next beat stored will be the last one of a word
//   empty_o     no beats stored
// ---------------------------------------------------------------------------
module im_beat_shifter
    import im_pkg::*;
#(
    parameter int BEAT_W = 6,
    parameter int K      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_i,
    input  logic              close_i,
    input  logic              drain_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
    localparam int FILL_W = K * BEAT_W;

    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [IDX_W-1:0]  idx_q;

    // Stored beats with this cycle's beat dropped into its slot.
    always_comb begin
        fill_d = fill_q;
        if (shift_i) begin
            fill_d[int'(idx_q) * BEAT_W +: BEAT_W] = beat_i;
        end
    end

    always_comb begin
        word_o               = '0;
        word_o[FILL_W-1:0]   = fill_d;
    end

    assign full_o  = (idx_q == IDX_W'(K - 1));
    assign empty_o = (idx_q == '0);

    // A closed or drained word restarts at beat index 0 with a clean register
    // so a later partial word is zero padded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            idx_q  <= '0;
        end else if (drain_i || (shift_i && close_i)) begin
            fill_q <= '0;
            idx_q  <= '0;
        end else if (shift_i) begin
            fill_q <= fill_d;
            idx_q  <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/im_data_packer.sv
// ---------------------------------------------------------------------------
// im_data_packer
// Packs CH*DATA_W-bit ADC sample beats into 32-bit words for a host pipe
// FIFO, frame by frame. A single output register holds the current word;
// a new word may load in the same cycle the previous one transfers.
//
// Configuration macro: IM_PACK_HEADER_EN
//   defined   - every frame is preceded by {8'hA5, frame_cnt, 8'(CH*DATA_W)}
//   undefined - data words only, frames start directly in PACK
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      arms frame capture; low ends capture after the current word
//   frame_len   sample beats per frame, sampled at frame start
//   in_data     sample beat, channel 0 in LSBs; in_valid / in_ready handshake
//   out_data    packed word; out_valid / out_ready handshake
//   frame_done  pulse on transfer of the last word of a completed frame
//   overflow    sticky: a beat was offered while in_ready was low
//   drop_cnt    number of dropped beats, saturating
// ---------------------------------------------------------------------------
module im_data_packer
    import im_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int CH     = 1,
    parameter int CNT_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CNT_W-1:0]     frame_len,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);

    localparam int BEAT_W = CH * DATA_W;
    localparam int K      = calc_beats_per_word(BEAT_W);

    if (K < 1) begin : g_beat_too_wide
        $error("im_data_packer: CH*DATA_W exceeds 32 bits, no beat fits a word");
    end

`ifdef IM_PACK_HEADER_EN
    localparam state_t FRAME_START = ST_HDR;
`else
    localparam state_t FRAME_START = ST_PACK;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic             eof_q;
    logic             last_word_q;
    logic [31:0]      out_data_q;
    logic             out_valid_q;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;
`ifdef IM_PACK_HEADER_EN
    logic [15:0]      frame_cnt_q;
`endif

    logic        out_free;
    logic        out_xfer;
    logic        beat_acc;
    logic        last_beat;
    logic        word_close;
    logic        shift_drain;
    logic        can_start;
    logic        shift_full;
    logic        shift_empty;
    logic [31:0] packed_word;

    assign out_free    = !out_valid_q || out_ready;
    assign out_xfer    = out_valid_q && out_ready;
    assign in_ready    = (state_q == ST_PACK) && out_free;
    assign beat_acc    = in_valid && in_ready;
    assign last_beat   = (pix_cnt_q == len_q - 1'b1);
    assign word_close  = shift_full || last_beat;
    assign shift_drain = (state_q == ST_FLUSH) && !shift_empty && out_free;
    assign can_start   = enable && (frame_len != '0);

    im_beat_shifter #(
        .BEAT_W (BEAT_W),
        .K      (K)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_i (beat_acc),
        .close_i (word_close),
        .drain_i (shift_drain),
        .beat_i  (in_data),
        .word_o  (packed_word),
        .full_o  (shift_full),
        .empty_o (shift_empty)
    );

    // Frame FSM, output register and error counters.
    // The frame's final beat always loads its (possibly partial) word in PACK
    // and moves to FLUSH, which then waits for that word to leave. An aborted
    // frame reaches FLUSH with beats still in the shifter; FLUSH loads them as
    // a zero-padded word marked not-last so no frame_done is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            pix_cnt_q   <= '0;
            eof_q       <= 1'b0;
            last_word_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
`ifdef IM_PACK_HEADER_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            if (out_xfer) begin
                out_valid_q <= 1'b0;
            end

            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (can_start) begin
                        len_q     <= frame_len;
                        pix_cnt_q <= '0;
                        eof_q     <= 1'b0;
                        state_q   <= FRAME_START;
                    end
                end

                ST_HDR: begin
`ifdef IM_PACK_HEADER_EN
                    if (out_free) begin
                        out_data_q  <= {HDR_SYNC, frame_cnt_q, 8'(BEAT_W)};
                        out_valid_q <= 1'b1;
                        last_word_q <= 1'b0;
                        state_q     <= ST_PACK;
                    end
`else
                    state_q <= ST_PACK;
`endif
                end

                ST_PACK: begin
                    if (beat_acc) begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                        if (word_close) begin
                            out_data_q  <= packed_word;
                            out_valid_q <= 1'b1;
                            last_word_q <= last_beat;
                        end
                        if (last_beat) begin
                            eof_q   <= 1'b1;
                            state_q <= ST_FLUSH;
                        end
                    end else if (!enable) begin
                        state_q <= shift_empty ? ST_IDLE : ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    if (!shift_empty) begin
                        if (out_free) begin
                            out_data_q  <= packed_word;
                            out_valid_q <= 1'b1;
                            last_word_q <= 1'b0;
                        end
                    end else if (!out_valid_q || out_xfer) begin
`ifdef IM_PACK_HEADER_EN
                        if (eof_q) begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
`endif
                        if (eof_q && can_start) begin
                            len_q     <= frame_len;
                            pix_cnt_q <= '0;
                            eof_q     <= 1'b0;
                            state_q   <= FRAME_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = out_xfer && last_word_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
